// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round functions used by the compression engine.
package sha256_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [255:0] digest_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam word_t IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32'sd32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // H0 lands in the most significant word of the digest.
  function automatic digest_t pack_words(input word_t w [0:7]);
    digest_t d;
    d = '0;
    for (int j = 0; j < 8; j++) begin
      d[255 - 32*j -: 32] = w[j];
    end
    return d;
  endfunction

endpackage

// File: rtl/sha256_compression_if.sv
// Block-level handshake and digest bus between the scheduler-side driver and the compression engine.
interface sha256_compression_if;
  import sha256_pkg::*;

  logic        start_i;
  logic        first_block_i;
  word_t       Wt_i;
  logic [5:0]  round_o;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  digest_t     digest_o;

  modport master (
    output start_i, first_block_i, Wt_i,
    input  round_o, ready_o, busy_o, done_o, digest_o
  );

  modport slave (
    input  start_i, first_block_i, Wt_i,
    output round_o, ready_o, busy_o, done_o, digest_o
  );

endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h in, next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  word_t wv      [0:7],
  input  word_t kt,
  input  word_t wt,
  output word_t wv_next [0:7]
);

  word_t t1_s;
  word_t t2_s;

  // round mixing; index 0..7 maps to a..h
  always_comb begin
    t1_s = wv[7] + big_sigma1(wv[4]) + ch(wv[4], wv[5], wv[6]) + kt + wt;
    t2_s = big_sigma0(wv[0]) + maj(wv[0], wv[1], wv[2]);
    wv_next[0] = t1_s + t2_s;
    wv_next[1] = wv[0];
    wv_next[2] = wv[1];
    wv_next[3] = wv[2];
    wv_next[4] = wv[3] + t1_s;
    wv_next[5] = wv[4];
    wv_next[6] = wv[5];
    wv_next[7] = wv[6];
  end

endmodule

// File: rtl/sha256_compression.sv
// SHA-256 compression engine: 64 rounds fed by the external scheduler, then fold into H and publish the digest.
module sha256_compression
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  sha256_compression_if.slave   bus
);

  localparam logic [5:0] LAST_CTR = 6'(ROUNDS - 1);

  state_t     state_r;
  state_t     state_next_s;
  logic       load_s;
  logic       last_round_s;
  logic [5:0] ctr_r;
  word_t      wv_r      [0:7];
  word_t      wv_next_s [0:7];
  word_t      h_r       [0:7];
  word_t      h_sum_s   [0:7];
  digest_t    digest_r;
  logic       done_r;
  logic       ready_r;
  logic       busy_r;

  sha256_round u_round (
    .wv      (wv_r),
    .kt      (K[ctr_r]),
    .wt      (bus.Wt_i),
    .wv_next (wv_next_s)
  );

  assign last_round_s = (ctr_r == LAST_CTR);

  // fold of the working variables into the chaining value
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      h_sum_s[j] = h_r[j] + wv_r[j];
    end
  end

  // next-state and load strobe; start outside IDLE is deliberately ignored
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start_i) begin
          state_next_s = ROUND;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ROUND: begin
        if (last_round_s) begin
          state_next_s = FINAL;
        end else begin
          state_next_s = ROUND;
        end
      end
      FINAL:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // round counter; cleared when leaving ROUND so round_o reads 0 outside rounds
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctr_r <= 6'd0;
    end else if (load_s) begin
      ctr_r <= 6'd0;
    end else if (state_r == ROUND) begin
      ctr_r <= last_round_s ? 6'd0 : ctr_r + 6'd1;
    end else begin
      ctr_r <= ctr_r;
    end
  end

  // working variables, hash state and published digest
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int j = 0; j < 8; j++) begin
        wv_r[j] <= IV[j];
        h_r[j]  <= IV[j];
      end
      digest_r <= pack_words(IV);
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start_i) begin
            for (int j = 0; j < 8; j++) begin
              wv_r[j] <= bus.first_block_i ? IV[j] : h_r[j];
              if (bus.first_block_i) begin
                h_r[j] <= IV[j];
              end
            end
          end
        end
        ROUND: begin
          for (int j = 0; j < 8; j++) begin
            wv_r[j] <= wv_next_s[j];
          end
        end
        FINAL: begin
          for (int j = 0; j < 8; j++) begin
            h_r[j] <= h_sum_s[j];
          end
          digest_r <= pack_words(h_sum_s);
        end
        default: begin
          digest_r <= digest_r;
        end
      endcase
    end
  end

  // registered status flags; done is the cycle after FINAL, which is also the first ready cycle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      done_r  <= (state_r == FINAL);
      ready_r <= (state_next_s == IDLE);
      busy_r  <= (state_next_s != IDLE);
    end
  end

  assign bus.round_o  = ctr_r;
  assign bus.ready_o  = ready_r;
  assign bus.busy_o   = busy_r;
  assign bus.done_o   = done_r;
  assign bus.digest_o = digest_r;

endmodule

// File: tb/tb_sha256_compression.sv
// Self-checking bench: known-answer digests plus random chained blocks against a loop-level SHA-256 model.
module tb_sha256_compression;

  logic clk;
  logic reset_i;
  int   checks;
  int   errors;

  sha256_compression_if bus();

  sha256_compression #(.ROUNDS(64)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] IVB [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic [31:0] KB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_DIG    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic [31:0]  mh [0:7];        // reference chaining value
  logic [255:0] snap_digest;
  logic [5:0]   snap_round;
  logic         snap_ready, snap_busy, snap_done, saw_done_in_reset;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic expand(input logic [31:0] m [0:15], output logic [31:0] w [0:63]);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[t];
      else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
  endtask

  task automatic model_block(input logic [31:0] m [0:15], input logic first);
    logic [31:0] w [0:63];
    logic [31:0] v [0:7];
    logic [31:0] t1, t2;
    expand(m, w);
    if (first) for (int j = 0; j < 8; j++) mh[j] = IVB[j];
    for (int j = 0; j < 8; j++) v[j] = mh[j];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KB[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) mh[j] = mh[j] + v[j];
  endtask

  function automatic logic [255:0] model_digest();
    logic [255:0] d;
    for (int j = 0; j < 8; j++) d[255 - 32*j -: 32] = mh[j];
    return d;
  endfunction

  // Starts a block at the current negedge; returns at the negedge where done_o is seen
  // (done_cyc = cycles after the start edge, -1 on timeout, -2 if reset was injected).
  task automatic run_block(input logic [31:0] m [0:15], input logic first, input int ign_at,
                           input int rst_at, output int done_cyc, output int round_bad);
    logic [31:0] w [0:63];
    expand(m, w);
    done_cyc  = -1;
    round_bad = 0;
    bus.start_i       = 1'b1;
    bus.first_block_i = first;
    bus.Wt_i          = $urandom;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      bus.start_i       = (n == ign_at);
      bus.first_block_i = 1'($urandom_range(0, 1));
      bus.Wt_i          = (n < 64) ? w[n] : $urandom;
      if (bus.done_o) begin
        done_cyc = n;
        bus.start_i = 1'b0;
        return;
      end
      if (n < 64 && bus.round_o !== 6'(n)) round_bad++;
      if (n <= 64 && bus.busy_o !== 1'b1) round_bad++;
      if (n == rst_at) begin
        reset_i = 1'b1;
        #1;
        snap_digest = bus.digest_o;
        snap_round  = bus.round_o;
        snap_ready  = bus.ready_o;
        snap_busy   = bus.busy_o;
        snap_done   = bus.done_o;
        bus.start_i = 1'b0;
        saw_done_in_reset = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (bus.done_o) saw_done_in_reset = 1'b1;
        end
        reset_i = 1'b0;
        repeat (30) begin
          @(negedge clk);
          if (bus.done_o) saw_done_in_reset = 1'b1;
        end
        done_cyc = -2;
        return;
      end
    end
    bus.start_i = 1'b0;
  endtask

  function automatic void pad_abc(output logic [31:0] m [0:15]);
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    m[0]  = 32'h61626380;
    m[15] = 32'h00000018;
  endfunction

  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks++; if (bus.digest_o !== IV_DIG) begin errors++; $display("FAIL reset_digest got %h want %h", bus.digest_o, IV_DIG); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_o); end
    checks++; if (bus.busy_o !== 1'b0 || bus.round_o !== 6'd0) begin errors++; $display("FAIL reset_busy_round got %b/%0d want 0/0", bus.busy_o, bus.round_o); end
  endtask

  task automatic test_abc();
    logic [31:0] m [0:15];
    int dc, rb;
    pad_abc(m);
    model_block(m, 1'b1);
    run_block(m, 1'b1, -1, -1, dc, rb);
    checks++; if (dc !== 65) begin errors++; $display("FAIL abc_latency got %0d want 65", dc); end
    checks++; if (rb !== 0) begin errors++; $display("FAIL abc_round_busy got %0d bad cycles want 0", rb); end
    checks++; if (bus.digest_o !== ABC_DIG) begin errors++; $display("FAIL abc_digest got %h want %h", bus.digest_o, ABC_DIG); end
    checks++; if (model_digest() !== ABC_DIG) begin errors++; $display("FAIL abc_model got %h want %h", model_digest(), ABC_DIG); end
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b0 || bus.digest_o !== ABC_DIG) begin errors++; $display("FAIL abc_pulse_hold got done=%b %h want done=0 %h", bus.done_o, bus.digest_o, ABC_DIG); end
  endtask

  task automatic test_empty();
    logic [31:0] m [0:15];
    int dc, rb;
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    m[0] = 32'h80000000;
    run_block(m, 1'b1, -1, -1, dc, rb);
    checks++; if (dc !== 65 || bus.digest_o !== EMPTY_DIG) begin errors++; $display("FAIL empty_digest got %h (lat %0d) want %h (lat 65)", bus.digest_o, dc, EMPTY_DIG); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b1 [0:15];
    logic [31:0] b2 [0:15];
    logic [31:0] txt [0:13] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                                32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                                32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
    int dc, rb;
    for (int i = 0; i < 16; i++) begin
      b1[i] = (i < 14) ? txt[i] : 32'h0;
      b2[i] = 32'h0;
    end
    b1[14] = 32'h80000000;
    b2[15] = 32'h000001c0;
    run_block(b1, 1'b1, -1, -1, dc, rb);
    checks++; if (dc !== 65 || bus.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got lat %0d ready %b want 65/1", dc, bus.ready_o); end
    run_block(b2, 1'b0, -1, -1, dc, rb);
    checks++; if (dc !== 65 || bus.digest_o !== TWO_DIG) begin errors++; $display("FAIL b2b_digest got %h (lat %0d) want %h", bus.digest_o, dc, TWO_DIG); end
  endtask

  task automatic test_random_chain();
    logic [31:0] m [0:15];
    int dc, rb;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) m[i] = $urandom;
      model_block(m, b == 0);
      run_block(m, b == 0, -1, -1, dc, rb);
      checks++; if (dc !== 65 || bus.digest_o !== model_digest()) begin errors++; $display("FAIL random_block%0d got %h (lat %0d) want %h", b, bus.digest_o, dc, model_digest()); end
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] m [0:15];
    int dc, rb;
    pad_abc(m);
    @(negedge clk);
    run_block(m, 1'b1, 30, -1, dc, rb);
    checks++; if (dc !== 65 || rb !== 0 || bus.digest_o !== ABC_DIG) begin errors++; $display("FAIL ignored_start got %h (lat %0d bad %0d) want %h", bus.digest_o, dc, rb, ABC_DIG); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] m [0:15];
    int dc, rb;
    logic [31:0] r [0:15];
    for (int i = 0; i < 16; i++) r[i] = $urandom;
    @(negedge clk);
    run_block(r, 1'b1, -1, 40, dc, rb);
    checks++; if (dc !== -2) begin errors++; $display("FAIL reset_mid_path got %0d want -2", dc); end
    checks++; if (snap_digest !== IV_DIG || snap_round !== 6'd0) begin errors++; $display("FAIL reset_mid_async got %h r%0d want %h r0", snap_digest, snap_round, IV_DIG); end
    checks++; if (snap_ready !== 1'b1 || snap_busy !== 1'b0 || snap_done !== 1'b0) begin errors++; $display("FAIL reset_mid_flags got rdy %b busy %b done %b want 1/0/0", snap_ready, snap_busy, snap_done); end
    checks++; if (saw_done_in_reset !== 1'b0) begin errors++; $display("FAIL reset_mid_no_done got %b want 0", saw_done_in_reset); end
    pad_abc(m);
    run_block(m, 1'b1, -1, -1, dc, rb);
    checks++; if (dc !== 65 || bus.digest_o !== ABC_DIG) begin errors++; $display("FAIL reset_mid_rerun got %h (lat %0d) want %h", bus.digest_o, dc, ABC_DIG); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_i = 1'b1;
    bus.start_i = 1'b0;
    bus.first_block_i = 1'b0;
    bus.Wt_i = 32'h0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_back_to_back();
    test_random_chain();
    test_ignored_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
